// File: rtl/uart_tx.sv
// UART transmit path: a host-side byte FIFO feeding a start/data/parity/stop serializer.
// The serial line, busy flag and FIFO flags are all registered.
module uart_tx #(
  parameter int DATA_BITS    = 8,
  parameter int FIFO_WIDTH   = 4,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_BITS-1:0]  Tx_Data,
  input  logic                  Push_Data,
  input  logic                  BIST_Mode,
  output logic                  Tx,
  output logic                  Tx_Busy,
  output logic                  FIFO_Empty,
  output logic                  FIFO_Full,
  output logic                  FIFO_Overflow,
  output logic [FIFO_WIDTH:0]   FIFO_Count,
  output logic [2:0]            dbg_state
);

  localparam int ENTRIES = 1 << FIFO_WIDTH;
  localparam int CNT_W   = FIFO_WIDTH + 1;
  localparam int BAUD_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0]  FULL_COUNT = CNT_W'(ENTRIES);
  localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  BIT_LAST   = IDX_W'(DATA_BITS - 1);
  localparam logic              PAR_ON     = (PARITY_EN != 0);
  localparam logic              PAR_ODD    = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [BAUD_W-1:0]     baud_q, baud_d;
  logic [IDX_W-1:0]      bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic                  parity_q, parity_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic [FIFO_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  empty_q, empty_d;
  logic                  full_q, full_d;
  logic                  ovf_q, ovf_d;
  logic [DATA_BITS-1:0]  mem_q [ENTRIES];

  logic pop, push_req, push_ok, baud_done;

  // Push_Data is a strobe with no ready: a high cycle either enqueues or, when the
  // FIFO is full and nothing pops that cycle, drops the byte and sets the sticky overflow.
  always_comb begin
    pop       = (state_q == S_IDLE) && (count_q != '0) && !BIST_Mode;
    push_req  = Push_Data && !BIST_Mode;
    push_ok   = push_req && ((count_q != FULL_COUNT) || pop);
    baud_done = (baud_q == BAUD_LAST);

    wr_ptr_d = push_ok ? wr_ptr_q + FIFO_WIDTH'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + FIFO_WIDTH'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push_ok && !pop) count_d = count_q + CNT_W'(1);
    if (!push_ok && pop) count_d = count_q - CNT_W'(1);
    empty_d  = (count_d == '0);
    full_d   = (count_d == FULL_COUNT);
    ovf_d    = ovf_q || (push_req && !push_ok);

    state_d   = state_q;
    baud_d    = (baud_done || state_q == S_IDLE) ? '0 : baud_q + BAUD_W'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          shift_d   = mem_q[rd_ptr_q];
          parity_d  = (^mem_q[rd_ptr_q]) ^ PAR_ODD;
          bit_idx_d = '0;
          state_d   = S_START;
        end
      end
      S_START:  if (baud_done) state_d = S_DATA;
      S_DATA: begin
        if (baud_done) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == BIT_LAST) begin
            bit_idx_d = '0;
            state_d   = PAR_ON ? S_PARITY : S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end
      end
      S_PARITY: if (baud_done) state_d = S_STOP;
      S_STOP:   if (baud_done) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // Line level is decoded from the next state so Tx changes on the same edge as the FSM.
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = parity_d;
      default:  tx_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      empty_q   <= empty_d;
      full_q    <= full_d;
      ovf_q     <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem_q[wr_ptr_q] <= Tx_Data;
  end

  assign Tx            = tx_q;
  assign Tx_Busy       = busy_q;
  assign FIFO_Empty    = empty_q;
  assign FIFO_Full     = full_q;
  assign FIFO_Overflow = ovf_q;
  assign FIFO_Count    = count_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three instances (no parity / even parity on a 4-deep FIFO / odd parity)
// share one stimulus stream; a queue-level model predicts FIFO state and byte order.
module tb_uart_tx;
  localparam int CPB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] tx_data = '0;
  logic push = 1'b0;
  logic bist = 1'b0;
  always #5 clk = ~clk;

  logic np_tx, np_busy, np_empty, np_full, np_ovf;
  logic [4:0] np_cnt;
  logic [2:0] np_dbg;
  logic ev_tx, ev_busy, ev_empty, ev_full, ev_ovf;
  logic [2:0] ev_cnt;
  logic [2:0] ev_dbg;
  logic od_tx, od_busy, od_empty, od_full, od_ovf;
  logic [4:0] od_cnt;
  logic [2:0] od_dbg;

  uart_tx #(.DATA_BITS(8), .FIFO_WIDTH(4), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0)) u_np (
    .clk(clk), .rst(rst), .Tx_Data(tx_data), .Push_Data(push), .BIST_Mode(bist),
    .Tx(np_tx), .Tx_Busy(np_busy), .FIFO_Empty(np_empty), .FIFO_Full(np_full),
    .FIFO_Overflow(np_ovf), .FIFO_Count(np_cnt), .dbg_state(np_dbg));
  uart_tx #(.DATA_BITS(8), .FIFO_WIDTH(2), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0)) u_ev (
    .clk(clk), .rst(rst), .Tx_Data(tx_data), .Push_Data(push), .BIST_Mode(bist),
    .Tx(ev_tx), .Tx_Busy(ev_busy), .FIFO_Empty(ev_empty), .FIFO_Full(ev_full),
    .FIFO_Overflow(ev_ovf), .FIFO_Count(ev_cnt), .dbg_state(ev_dbg));
  uart_tx #(.DATA_BITS(8), .FIFO_WIDTH(4), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1)) u_od (
    .clk(clk), .rst(rst), .Tx_Data(tx_data), .Push_Data(push), .BIST_Mode(bist),
    .Tx(od_tx), .Tx_Busy(od_busy), .FIFO_Empty(od_empty), .FIFO_Full(od_full),
    .FIFO_Overflow(od_ovf), .FIFO_Count(od_cnt), .dbg_state(od_dbg));

  int total = 0;
  int bad = 0;

  // Queue-level reference: transmitter is free again one idle cycle after a frame ends.
  int m_t = 0;
  int m_np_free = 0, m_ev_free = 0;
  bit m_np_ovf = 1'b0, m_ev_ovf = 1'b0;
  logic [7:0] m_np_q[$], m_ev_q[$];
  logic [7:0] exp_np_q[$], exp_ev_q[$];

  always @(posedge clk) begin : model
    bit pop_n, acc_n, pop_e, acc_e;
    m_t = m_t + 1;
    if (rst) begin
      m_np_q.delete(); m_ev_q.delete(); exp_np_q.delete(); exp_ev_q.delete();
      m_np_free = 0; m_ev_free = 0; m_np_ovf = 1'b0; m_ev_ovf = 1'b0;
    end else begin
      pop_n = (m_t >= m_np_free) && (m_np_q.size() > 0) && !bist;
      acc_n = push && !bist && ((m_np_q.size() < 16) || pop_n);
      if (push && !bist && !acc_n) m_np_ovf = 1'b1;
      if (pop_n) begin exp_np_q.push_back(m_np_q.pop_front()); m_np_free = m_t + 10 * CPB + 1; end
      if (acc_n) m_np_q.push_back(tx_data);
      pop_e = (m_t >= m_ev_free) && (m_ev_q.size() > 0) && !bist;
      acc_e = push && !bist && ((m_ev_q.size() < 4) || pop_e);
      if (push && !bist && !acc_e) m_ev_ovf = 1'b1;
      if (pop_e) begin exp_ev_q.push_back(m_ev_q.pop_front()); m_ev_free = m_t + 11 * CPB + 1; end
      if (acc_e) m_ev_q.push_back(tx_data);
    end
  end

  logic rec = 1'b0;
  logic tr_np[$], tr_ev[$];
  always @(negedge clk) if (rec) begin tr_np.push_back(np_tx); tr_ev.push_back(ev_tx); end

  logic dq[$];
  logic [7:0] dec_bytes[$];
  int dec_starts[$];
  int dec_errs;

  // Frame decoder over a sampled line trace: every bit must hold for CPB samples.
  task automatic decode(input int pe, input int odd);
    int i, nb, len, pos;
    logic v;
    logic [7:0] b;
    nb = 10 + pe; len = nb * CPB; i = 0;
    dec_bytes.delete(); dec_starts.delete(); dec_errs = 0;
    while (i < dq.size()) begin
      if (dq[i] === 1'b0) begin
        if (i + len > dq.size()) begin dec_errs++; break; end
        b = '0;
        for (int k = 0; k < nb; k++) begin
          pos = i + k * CPB;
          v = dq[pos];
          for (int c = 1; c < CPB; c++) if (dq[pos + c] !== v) dec_errs++;
          if (k >= 1 && k <= 8) b[k-1] = v;
          else if (pe != 0 && k == 9) begin if (v !== ((^b) ^ (odd != 0))) dec_errs++; end
          else if (k == nb - 1) begin if (v !== 1'b1) dec_errs++; end
        end
        dec_bytes.push_back(b); dec_starts.push_back(i);
        i += len;
      end else i++;
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int pe, input int odd, input int s);
    int k;
    if (s < 1 || s > (10 + pe) * CPB) return 1'b1;
    k = (s - 1) / CPB;
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (pe != 0 && k == 9) return (^b) ^ (odd != 0);
    return 1'b1;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rec = 1'b0; push = 1'b0; bist = 1'b0; rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tr_np.delete(); tr_ev.delete(); rec = 1'b1;
  endtask

  task automatic wait_drain();
    int g = 0;
    while (g < 3000 && !(m_np_q.size() == 0 && m_ev_q.size() == 0 && m_t >= m_np_free && m_t >= m_ev_free)) begin
      tick(); g++;
    end
    repeat (3) tick();
    total++;
    if (g >= 3000) begin bad++; $display("FAIL drain_timeout: waited %0d cycles, limit 3000", g); end
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick();
    total++;
    if ({np_tx, np_busy, np_empty, np_full, np_ovf, np_cnt} !== {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0}) begin
      bad++; $display("FAIL reset_np: tx/busy/empty/full/ovf/cnt=%b%b%b%b%b/%0d want 10100/0",
                      np_tx, np_busy, np_empty, np_full, np_ovf, np_cnt);
    end
    total++;
    if ({ev_tx, ev_busy, ev_empty, ev_full, ev_ovf, ev_cnt} !== {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0}) begin
      bad++; $display("FAIL reset_ev: tx/busy/empty/full/ovf/cnt=%b%b%b%b%b/%0d want 10100/0",
                      ev_tx, ev_busy, ev_empty, ev_full, ev_ovf, ev_cnt);
    end
    total++;
    if ({od_tx, od_busy, od_empty, od_cnt} !== {1'b1, 1'b0, 1'b1, 5'd0}) begin
      bad++; $display("FAIL reset_od: tx/busy/empty/cnt=%b%b%b/%0d want 101/0", od_tx, od_busy, od_empty, od_cnt);
    end
    rst = 1'b0; tick();
  endtask

  task automatic test_single_frame(input logic [7:0] b);
    int np_err = 0, ev_err = 0, od_err = 0, np_busy_n = 0, ev_busy_n = 0, first_busy = -1;
    logic ev_par = 1'bx, od_par = 1'bx;
    apply_reset();
    tx_data = b; push = 1'b1; tick(); push = 1'b0;
    total++;
    if (np_empty !== 1'b0 || np_cnt !== 5'd1) begin
      bad++; $display("FAIL push_latency: empty=%b count=%0d want empty=0 count=1", np_empty, np_cnt);
    end
    for (int s = 0; s < 50; s++) begin
      if (s > 0) tick();
      if (np_tx !== frame_bit(b, 0, 0, s)) np_err++;
      if (ev_tx !== frame_bit(b, 1, 0, s)) ev_err++;
      if (od_tx !== frame_bit(b, 1, 1, s)) od_err++;
      if (np_busy === 1'b1) begin np_busy_n++; if (first_busy < 0) first_busy = s; end
      if (ev_busy === 1'b1) ev_busy_n++;
      if (s == 1 + 9 * CPB) begin ev_par = ev_tx; od_par = od_tx; end
    end
    total++; if (np_err != 0) begin bad++; $display("FAIL frame_np 0x%h: %0d wrong samples, want 0", b, np_err); end
    total++; if (ev_err != 0) begin bad++; $display("FAIL frame_even 0x%h: %0d wrong samples, want 0", b, ev_err); end
    total++; if (od_err != 0) begin bad++; $display("FAIL frame_odd 0x%h: %0d wrong samples, want 0", b, od_err); end
    total++; if (ev_par !== (^b)) begin bad++; $display("FAIL parity_even 0x%h: got %b want %b", b, ev_par, ^b); end
    total++; if (od_par !== ~(^b)) begin bad++; $display("FAIL parity_odd 0x%h: got %b want %b", b, od_par, ~(^b)); end
    total++; if (np_busy_n != 40 || first_busy != 1) begin
      bad++; $display("FAIL busy_np: %0d cycles from sample %0d, want 40 from 1", np_busy_n, first_busy);
    end
    total++; if (ev_busy_n != 44) begin bad++; $display("FAIL busy_even: %0d cycles, want 44", ev_busy_n); end
  endtask

  task automatic test_overflow();
    int mis = 0, gap_bad = 0;
    apply_reset();
    bist = 1'b1; tx_data = 8'($urandom_range(0, 255)); push = 1'b1; tick(); push = 1'b0;
    total++;
    if (ev_cnt !== 3'd0 || ev_ovf !== 1'b0) begin
      bad++; $display("FAIL bist_push_ignored: count=%0d ovf=%b want 0/0", ev_cnt, ev_ovf);
    end
    for (int i = 0; i < 7; i++) begin
      bist = 1'b0; tx_data = 8'($urandom_range(0, 255)); push = 1'b1; tick();
      total++; if (ev_cnt !== 3'(m_ev_q.size())) begin
        bad++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, ev_cnt, m_ev_q.size());
      end
      total++; if (ev_full !== (m_ev_q.size() == 4)) begin
        bad++; $display("FAIL fill_full[%0d]: got %b want %b", i, ev_full, m_ev_q.size() == 4);
      end
      total++; if (ev_ovf !== m_ev_ovf) begin
        bad++; $display("FAIL fill_ovf[%0d]: got %b want %b", i, ev_ovf, m_ev_ovf);
      end
    end
    push = 1'b0;
    wait_drain();
    total++; if (ev_ovf !== 1'b1 || ev_empty !== 1'b1) begin
      bad++; $display("FAIL ovf_sticky: ovf=%b empty=%b want 1/1", ev_ovf, ev_empty);
    end
    dq = tr_ev; decode(1, 0);
    for (int k = 0; k < dec_bytes.size(); k++) begin
      if (k >= exp_ev_q.size() || dec_bytes[k] !== exp_ev_q[k]) mis++;
      if (k > 0 && dec_starts[k] - dec_starts[k-1] != 11 * CPB + 1) gap_bad++;
    end
    total++; if (dec_errs != 0 || dec_bytes.size() != 5 || mis != 0) begin
      bad++; $display("FAIL ovf_order: frames=%0d errs=%0d mismatches=%0d want 5/0/0", dec_bytes.size(), dec_errs, mis);
    end
    total++; if (gap_bad != 0) begin bad++; $display("FAIL ovf_gap: %0d bad gaps want 0", gap_bad); end
  endtask

  task automatic test_wrap();
    int sent = 0, guard = 0, full_err = 0, mis = 0, gap_bad = 0;
    bit saw_full = 1'b0;
    apply_reset();
    while (sent < 20 && guard < 3000) begin
      if (m_np_q.size() < 16) begin tx_data = 8'(sent); push = 1'b1; sent++; end
      else push = 1'b0;
      tick(); guard++;
      if (np_full === 1'b1) saw_full = 1'b1;
      if (np_full !== (m_np_q.size() == 16)) full_err++;
    end
    push = 1'b0;
    total++; if (sent != 20) begin bad++; $display("FAIL wrap_push_timeout: pushed %0d want 20", sent); end
    wait_drain();
    total++; if (saw_full !== 1'b1 || full_err != 0) begin
      bad++; $display("FAIL wrap_full: seen=%b flag_errors=%0d want 1/0", saw_full, full_err);
    end
    total++; if (np_ovf !== 1'b0) begin bad++; $display("FAIL wrap_ovf: got %b want 0", np_ovf); end
    dq = tr_np; decode(0, 0);
    for (int k = 0; k < dec_bytes.size(); k++) begin
      if (dec_bytes[k] !== 8'(k) || k >= exp_np_q.size() || dec_bytes[k] !== exp_np_q[k]) mis++;
      if (k > 0 && dec_starts[k] - dec_starts[k-1] != 10 * CPB + 1) gap_bad++;
    end
    total++; if (dec_errs != 0 || dec_bytes.size() != 20 || mis != 0) begin
      bad++; $display("FAIL wrap_order: frames=%0d errs=%0d mismatches=%0d want 20/0/0", dec_bytes.size(), dec_errs, mis);
    end
    total++; if (gap_bad != 0) begin bad++; $display("FAIL wrap_gap: %0d bad gaps want 0", gap_bad); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b0;
    int zeros = 0;
    apply_reset();
    b0 = 8'($urandom_range(0, 255));
    for (int i = 0; i < 6; i++) begin
      tx_data = (i == 0) ? b0 : 8'($urandom_range(0, 255)); push = 1'b1; tick();
    end
    push = 1'b0;
    repeat (12) tick();
    total++; if (np_tx !== b0[3] || np_busy !== 1'b1 || ev_ovf !== m_ev_ovf) begin
      bad++; $display("FAIL pre_reset: tx=%b busy=%b ev_ovf=%b want %b/1/%b", np_tx, np_busy, ev_ovf, b0[3], m_ev_ovf);
    end
    rec = 1'b0; rst = 1'b1; tick(); rst = 1'b0;
    total++;
    if ({np_tx, np_busy, np_empty, np_ovf, np_cnt, ev_ovf} !== {1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0}) begin
      bad++; $display("FAIL reset_mid: tx/busy/empty/ovf/cnt/ev_ovf=%b%b%b%b/%0d/%b want 1010/0/0",
                      np_tx, np_busy, np_empty, np_ovf, np_cnt, ev_ovf);
    end
    tr_np.delete(); rec = 1'b1;
    repeat (100) tick();
    foreach (tr_np[k]) if (tr_np[k] !== 1'b1) zeros++;
    total++; if (zeros != 0 || np_busy !== 1'b0) begin
      bad++; $display("FAIL reset_quiet: %0d non-idle samples busy=%b want 0/0", zeros, np_busy);
    end
  endtask

  task automatic test_bist_mid();
    logic [7:0] b0, b1;
    apply_reset();
    b0 = 8'($urandom_range(0, 255)); b1 = 8'($urandom_range(0, 255));
    tx_data = b0; push = 1'b1; tick();
    tx_data = b1; tick();
    push = 1'b0;
    total++; if (np_tx !== 1'b0 || np_busy !== 1'b1) begin
      bad++; $display("FAIL bist_start: tx=%b busy=%b want 0/1", np_tx, np_busy);
    end
    bist = 1'b1;
    repeat (80) tick();
    total++; if ({np_tx, np_busy, np_cnt} !== {1'b1, 1'b0, 5'd1}) begin
      bad++; $display("FAIL bist_hold: tx=%b busy=%b count=%0d want 1/0/1", np_tx, np_busy, np_cnt);
    end
    dq = tr_np; decode(0, 0);
    total++; if (dec_errs != 0 || dec_bytes.size() != 1 || dec_bytes[0] !== b0) begin
      bad++; $display("FAIL bist_first: frames=%0d errs=%0d want 1 frame of 0x%h", dec_bytes.size(), dec_errs, b0);
    end
    bist = 1'b0;
    repeat (60) tick();
    dq = tr_np; decode(0, 0);
    total++; if (dec_errs != 0 || dec_bytes.size() != 2 || dec_bytes[0] !== b0 || dec_bytes[1] !== b1) begin
      bad++; $display("FAIL bist_resume: frames=%0d errs=%0d want 2 frames 0x%h 0x%h", dec_bytes.size(), dec_errs, b0, b1);
    end
    total++; if (np_empty !== 1'b1) begin bad++; $display("FAIL bist_drained: empty=%b want 1", np_empty); end
  endtask

  initial begin
    test_reset();
    test_single_frame(8'hA5);
    test_single_frame(8'($urandom_range(0, 255)));
    test_single_frame(8'($urandom_range(0, 255)));
    test_overflow();
    test_wrap();
    test_reset_mid();
    test_bist_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Transmit half of the UART. It buffers bytes written by the host in an internal FIFO of 2^FIFO_WIDTH entries and serializes each one onto the `Tx` line as a standard asynchronous frame. The frame is a start bit, DATA_BITS data bits LSB first, an optional parity bit and one stop bit. It sits between the host/bus side and the serial pin, mirroring the receive path's FIFO semantics in the opposite direction.

## Interface
- `DATA_BITS`, 8, width of one character
- `FIFO_WIDTH`, 4, log2 of FIFO depth (FIFO_ENTRIES = 2**FIFO_WIDTH)
- `CLKS_PER_BIT`, 16, clk cycles per serial bit (≥2)
- `PARITY_EN`, 0, 1 inserts a parity bit after the data bits
- `PARITY_ODD`, 0, 0 = even parity, 1 = odd parity (ignored if PARITY_EN=0)

- `clk`  in  1  single clock; all logic on posedge
- `rst`  in  1  synchronous, active-high reset
- `Tx_Data`  in  DATA_BITS  byte to enqueue
- `Push_Data`  in  1  write strobe, sampled each clk; one enqueue per high cycle
- `BIST_Mode`  in  1  high: ignore pushes, start no new frames
- `Tx`  out  1  serial line, idle high
- `Tx_Busy`  out  1  high whenever the FSM is not IDLE
- `FIFO_Empty`  out  1  count == 0
- `FIFO_Full`  out  1  count == FIFO_ENTRIES (true full, not half)
- `FIFO_Overflow`  out  1  sticky; a push was dropped
- `FIFO_Count`  out  FIFO_WIDTH+1  current number of entries

## Operation
- Reset: pointers = 0, count = 0, FSM = IDLE, baud counter = 0, `Tx`=1, `Tx_Busy`=0, `FIFO_Empty`=1, `FIFO_Full`=0, `FIFO_Overflow`=0, `FIFO_Count`=0. Reset mid-frame aborts immediately; `Tx` is 1 the cycle after.
- Push: accepted if `Push_Data`=1, `BIST_Mode`=0 and count < FIFO_ENTRIES; data is written at writePointer, and the pointer increments modulo FIFO_ENTRIES (natural wrap).
- Push while full: data is dropped and `FIFO_Overflow` is set. It stays set until `rst`.
- Pop: internal only. It occurs in IDLE when count > 0 and `BIST_Mode`=0. The head entry loads into the shift register and readPointer increments with wrap.
- Simultaneous push and pop: both take effect and count is unchanged. If full, the same-cycle pop frees a slot, so the push is accepted and no overflow occurs.
- FSM states:
  - IDLE: `Tx`=1. Pops if allowed, then goes to START.
  - START: `Tx`=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: `Tx`=shift[0] for CLKS_PER_BIT cycles per bit, shifting right. After DATA_BITS bits it goes to PARITY if PARITY_EN=1, else STOP.
  - PARITY: `Tx` = XOR of the data bits, XOR PARITY_ODD, for CLKS_PER_BIT cycles, then STOP.
  - STOP: `Tx`=1 for CLKS_PER_BIT cycles, then IDLE.
- Baud counter: 0..CLKS_PER_BIT-1. It clears on every state/bit transition. Its width is clog2(CLKS_PER_BIT).
- Bit index counter: 0..DATA_BITS-1, used only in DATA.
- `BIST_Mode` rising mid-frame: the current frame completes normally, then the FSM holds in IDLE. FIFO contents are preserved.

## Timing
- `FIFO_Empty`, `FIFO_Full` and `FIFO_Count` are registered and reflect a push/pop one cycle after the strobe edge.
- Latency: a push at edge N into an empty FIFO with the FSM in IDLE gives `FIFO_Empty`=0 after edge N. The pop occurs at edge N+1, and `Tx` falls after edge N+1 (START).
- Frame length: (2 + DATA_BITS + PARITY_EN) × CLKS_PER_BIT cycles.
- Back-to-back frames: exactly one IDLE cycle (`Tx`=1) between a stop bit and the next start bit.
- `Tx_Busy` rises with START and falls on the cycle the FSM re-enters IDLE.

## Test plan
- Single byte, CLKS_PER_BIT=4, no parity: push 0xA5. `Tx` must show 0 then 1,0,1,0,0,1,0,1 then 1, each held 4 cycles (40 cycles total). Start bit begins 2 cycles after the push; `Tx_Busy` is high for 40 cycles.
- Even parity: PARITY_EN=1, PARITY_ODD=0, push 0xA5 → parity bit 0. With PARITY_ODD=1 the parity bit is 1, and the frame is 44 cycles.
- Fill/overflow, FIFO_WIDTH=2: hold `BIST_Mode`=1, push 1 byte, and check it is ignored (count 0). Drop `BIST_Mode` and push 5 bytes back-to-back in the same cycle as the first pop. The bench must check that `FIFO_Full` and `FIFO_Overflow` match the count/pop rules, and that all accepted bytes are transmitted in order.
- Wrap-around: push and transmit 20 bytes 0x00..0x13 through a 16-entry FIFO. Serial output order must be identical, with one idle cycle between frames.
- Reset mid-frame: assert `rst` during DATA bit 3. The next cycle must show `Tx`=1, `Tx_Busy`=0, `FIFO_Empty`=1 and `FIFO_Overflow`=0, and no further frame is emitted.
- BIST mid-frame: raise `BIST_Mode` during START with 2 bytes queued. The current frame completes, then `Tx` stays 1 and `FIFO_Count`=1. Lowering `BIST_Mode` resumes the remaining frame.
